// File: rtl/instr_unescape_fetch.sv
// Instruction byte unescape/fetch: strips legacy prefixes and the 0x0F
// escape and packs body bytes into a 72-bit window. Option: SEGMENT_PREFIX_EN.
module instr_unescape_fetch #(
    parameter int MAX_PREFIXES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [71:0] unescaped_instr,
    output logic        prefix_operand_16bit,
    output logic        prefix_address_16bit,
    output logic        prefix_lock,
    output logic [1:0]  prefix_rep,
    output logic [2:0]  prefix_seg,
    output logic        escape_0f,
    output logic [3:0]  instr_len,
    output logic        instr_error
);

    typedef enum logic [1:0] {
        S_PREFIX,
        S_BODY,
        S_HOLD
    } state_t;

    localparam logic [3:0] MAX_P = 4'(MAX_PREFIXES);

    state_t     state;
    state_t     state_nxt;
    logic       take;
    logic       is_pfx;
    logic [2:0] seg_code;
    logic [3:0] body_idx;
    logic [3:0] pfx_cnt;

    assign take = byte_valid && byte_ready;

    // Segment override decode; without the option these bytes are plain data.
    always_comb begin
        seg_code = 3'd0;
`ifdef SEGMENT_PREFIX_EN
        case (byte_data)
            8'h26:   seg_code = 3'd1;
            8'h2E:   seg_code = 3'd2;
            8'h36:   seg_code = 3'd3;
            8'h3E:   seg_code = 3'd4;
            8'h64:   seg_code = 3'd5;
            8'h65:   seg_code = 3'd6;
            default: seg_code = 3'd0;
        endcase
`endif
    end

    assign is_pfx = (byte_data == 8'h66) || (byte_data == 8'h67) ||
                    (byte_data == 8'hF0) || (byte_data == 8'hF2) ||
                    (byte_data == 8'hF3) || (seg_code != 3'd0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_PREFIX;
        else     state <= state_nxt;
    end

    // Next-state: prefixes loop in S_PREFIX, byte_last always ends the frame.
    always_comb begin
        state_nxt = state;
        case (state)
            S_PREFIX: begin
                if (take) begin
                    if (byte_last)    state_nxt = S_HOLD;
                    else if (!is_pfx) state_nxt = S_BODY;
                end
            end
            S_BODY: begin
                if (take && byte_last) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (instr_ready) state_nxt = S_PREFIX;
            end
            default: state_nxt = S_PREFIX;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        byte_ready  = (state != S_HOLD);
        instr_valid = (state == S_HOLD);
    end

    // Datapath: accumulate flags, body bytes, length and error per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || (state == S_HOLD && instr_ready)) begin
            unescaped_instr      <= '0;
            prefix_operand_16bit <= 1'b0;
            prefix_address_16bit <= 1'b0;
            prefix_lock          <= 1'b0;
            prefix_rep           <= 2'b00;
            prefix_seg           <= 3'd0;
            escape_0f            <= 1'b0;
            instr_len            <= 4'd0;
            instr_error          <= 1'b0;
            body_idx             <= 4'd0;
            pfx_cnt              <= 4'd0;
        end else if (take) begin
            if (instr_len != 4'd15) instr_len <= instr_len + 4'd1;
            if (state == S_PREFIX) begin
                if (is_pfx) begin
                    case (byte_data)
                        8'h66:   prefix_operand_16bit <= 1'b1;
                        8'h67:   prefix_address_16bit <= 1'b1;
                        8'hF0:   prefix_lock <= 1'b1;
                        8'hF3:   prefix_rep <= 2'b01;
                        8'hF2:   prefix_rep <= 2'b10;
                        default: prefix_seg <= seg_code;
                    endcase
                    if (pfx_cnt != 4'd15) pfx_cnt <= pfx_cnt + 4'd1;
                    if (pfx_cnt + 4'd1 > MAX_P) instr_error <= 1'b1;
                    if (byte_last) instr_error <= 1'b1;
                end else if (byte_data == 8'h0F) begin
                    escape_0f <= 1'b1;
                    if (byte_last) instr_error <= 1'b1;
                end else begin
                    unescaped_instr[7:0] <= byte_data;
                    body_idx             <= 4'd1;
                end
            end else if (state == S_BODY) begin
                if (body_idx < 4'd9) begin
                    for (int k = 0; k < 9; k++) begin
                        if (body_idx == 4'(k))
                            unescaped_instr[8*k +: 8] <= byte_data;
                    end
                    body_idx <= body_idx + 4'd1;
                end else begin
                    instr_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_unescape_fetch.sv
// Randomized bench for instr_unescape_fetch against a frame-level model.
// Build with SEGMENT_PREFIX_EN to exercise segment overrides.
module tb_instr_unescape_fetch;

    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        instr_valid;
    logic        instr_ready;
    logic [71:0] unescaped_instr;
    logic        prefix_operand_16bit;
    logic        prefix_address_16bit;
    logic        prefix_lock;
    logic [1:0]  prefix_rep;
    logic [2:0]  prefix_seg;
    logic        escape_0f;
    logic [3:0]  instr_len;
    logic        instr_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [71:0] win;
        logic        op16;
        logic        a16;
        logic        lock;
        logic [1:0]  rep;
        logic [2:0]  seg;
        logic        esc;
        logic [3:0]  len;
        logic        err;
    } exp_t;

    instr_unescape_fetch #(.MAX_PREFIXES(MAXP)) dut (
        .clk(clk),
        .rst(rst),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_last(byte_last),
        .byte_ready(byte_ready),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .unescaped_instr(unescaped_instr),
        .prefix_operand_16bit(prefix_operand_16bit),
        .prefix_address_16bit(prefix_address_16bit),
        .prefix_lock(prefix_lock),
        .prefix_rep(prefix_rep),
        .prefix_seg(prefix_seg),
        .escape_0f(escape_0f),
        .instr_len(instr_len),
        .instr_error(instr_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int seg_of(input logic [7:0] b);
`ifdef SEGMENT_PREFIX_EN
        if (b == 8'h26) return 1;
        if (b == 8'h2E) return 2;
        if (b == 8'h36) return 3;
        if (b == 8'h3E) return 4;
        if (b == 8'h64) return 5;
        if (b == 8'h65) return 6;
`endif
        return (b == 8'h00) ? 0 : 0;
    endfunction

    function automatic bit pfx_byte(input logic [7:0] b);
        return b == 8'h66 || b == 8'h67 || b == 8'hF0 ||
               b == 8'hF2 || b == 8'hF3 || seg_of(b) != 0;
    endfunction

    // Frame-level reference: leading prefixes, optional escape, rest is body.
    function automatic exp_t model(input logic [7:0] b[$]);
        exp_t e;
        int   i = 0;
        int   np = 0;
        int   nb;
        e = '{win: '0, op16: 0, a16: 0, lock: 0, rep: 0, seg: 0,
              esc: 0, len: 0, err: 0};
        while (i < b.size() && pfx_byte(b[i])) begin
            if (b[i] == 8'h66) e.op16 = 1;
            if (b[i] == 8'h67) e.a16 = 1;
            if (b[i] == 8'hF0) e.lock = 1;
            if (b[i] == 8'hF3) e.rep = 2'b01;
            if (b[i] == 8'hF2) e.rep = 2'b10;
            if (seg_of(b[i]) != 0) e.seg = 3'(seg_of(b[i]));
            np++;
            i++;
        end
        if (i < b.size() && b[i] == 8'h0F) begin
            e.esc = 1;
            i++;
        end
        nb = b.size() - i;
        for (int k = 0; k < nb && k < 9; k++) e.win[8*k +: 8] = b[i+k];
        e.err = (np > MAXP) || (nb == 0) || (nb > 9);
        e.len = (b.size() > 15) ? 4'd15 : 4'(b.size());
        return e;
    endfunction

    task automatic check_out(input string t, input exp_t e);
        check({t, ".win"}, unescaped_instr, e.win);
        check({t, ".op16"}, 72'(prefix_operand_16bit), 72'(e.op16));
        check({t, ".a16"}, 72'(prefix_address_16bit), 72'(e.a16));
        check({t, ".lock"}, 72'(prefix_lock), 72'(e.lock));
        check({t, ".rep"}, 72'(prefix_rep), 72'(e.rep));
        check({t, ".seg"}, 72'(prefix_seg), 72'(e.seg));
        check({t, ".esc"}, 72'(escape_0f), 72'(e.esc));
        check({t, ".len"}, 72'(instr_len), 72'(e.len));
        check({t, ".err"}, 72'(instr_error), 72'(e.err));
    endtask

    // Send one frame with random gaps, then verify hold and handoff.
    task automatic run_instr(input string t, input logic [7:0] b[$]);
        exp_t z;
        exp_t e;
        int   hold;
        e = model(b);
        z = model('{8'h00});
        z.len = 0;
        z.err = 0;
        for (int i = 0; i < b.size(); i++) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            byte_valid = 1'b1;
            byte_data  = b[i];
            byte_last  = (i == b.size() - 1);
            check({t, ".rdy"}, 72'(byte_ready), 72'd1);
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
            byte_last  = 1'b0;
        end
        check({t, ".vld"}, 72'(instr_valid), 72'd1);
        check({t, ".brdy"}, 72'(byte_ready), 72'd0);
        check_out(t, e);
        hold = $urandom_range(0, 4);
        repeat (hold) begin
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
            byte_last  = 1'($urandom);
            @(posedge clk);
            #1;
            check({t, ".hvld"}, 72'(instr_valid), 72'd1);
            check({t, ".hrdy"}, 72'(byte_ready), 72'd0);
            check({t, ".hwin"}, unescaped_instr, e.win);
            check({t, ".hlen"}, 72'(instr_len), 72'(e.len));
        end
        byte_valid  = 1'b0;
        byte_last   = 1'b0;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        check({t, ".done"}, 72'(instr_valid), 72'd0);
        check({t, ".clr"}, unescaped_instr, 72'd0);
        check({t, ".clen"}, 72'(instr_len), 72'd0);
        check({t, ".cerr"}, 72'(instr_error), 72'd0);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] pool[12];
        pool = '{8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h0F,
                 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
        if ($urandom_range(0, 9) < 5) return pool[$urandom_range(0, 11)];
        return 8'($urandom);
    endfunction

    initial begin
        logic [7:0] q[$];
        exp_t       z;
        rst         = 1'b1;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        byte_last   = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        z = model('{8'h00});
        z.len = 0;
        z.err = 0;
        check("rst.rdy", 72'(byte_ready), 72'd1);
        check("rst.vld", 72'(instr_valid), 72'd0);
        check_out("rst", z);
        rst = 1'b0;

        run_instr("t1", '{8'h01, 8'hC8});
        run_instr("t2", '{8'h66, 8'h67, 8'hF3, 8'h0F, 8'hAF, 8'hC1});
        run_instr("t3", '{8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h90});
        run_instr("t4", '{8'h66, 8'h66, 8'h66, 8'h66, 8'h90});
        run_instr("t5", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                          8'h06, 8'h07, 8'h08, 8'h09, 8'h0A});
        run_instr("t6", '{8'h66});
        run_instr("t7", '{8'h0F});
        run_instr("t8", '{8'hF3, 8'hF2, 8'h0F, 8'h0F});
        run_instr("t9", '{8'h64, 8'h8B, 8'h00});
        run_instr("t10", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                           8'h77, 8'h88, 8'h99});

        byte_data  = 8'h01;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_data = 8'h02;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid.rdy", 72'(byte_ready), 72'd1);
        check("mid.vld", 72'(instr_valid), 72'd0);
        check_out("mid", z);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr("post", '{8'hF0, 8'h90});

        for (int n = 0; n < 200; n++) begin
            int len;
            q.delete();
            len = $urandom_range(1, 17);
            for (int i = 0; i < len; i++) q.push_back(rand_byte());
            run_instr("rnd", q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
